// File: rtl/RoCE_params.sv
// Shared RoCEv2 requester constants and types.
// Includes the RNR back-off state encoding and the IBTA RNR NAK timer table.
package RoCE_params;

  localparam int MAX_QUEUE_PAIRS       = 4;
  localparam int MAX_QUEUE_PAIRS_WIDTH = 2;

  typedef enum logic [1:0] {RNR_IDLE, RNR_WAIT, RNR_PENDING, RNR_ISSUED} rnr_state_t;

  localparam logic [2:0] RNR_RETRY_INFINITE = 3'd7;

  // IBTA RNR NAK timer table expressed in 100 MHz clock cycles, indexed by the 5-bit AETH code.
  localparam logic [31:0] RNR_TIMER_VALUES [32] = '{
    32'd65536000, 32'd1000,     32'd2000,     32'd3000,
    32'd4000,     32'd6000,     32'd8000,     32'd12000,
    32'd16000,    32'd24000,    32'd32000,    32'd48000,
    32'd64000,    32'd96000,    32'd128000,   32'd192000,
    32'd256000,   32'd384000,   32'd512000,   32'd768000,
    32'd1024000,  32'd1536000,  32'd2048000,  32'd3072000,
    32'd4096000,  32'd6144000,  32'd8192000,  32'd12288000,
    32'd16384000, 32'd24576000, 32'd32768000, 32'd49152000
  };

  function automatic logic [31:0] rnr_timer_load(input logic [4:0] code,
                                                 input int unsigned shift);
    logic [31:0] v;
    v = RNR_TIMER_VALUES[code] >> shift;
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/roce_rr_arbiter.sv
// Round-robin request/grant arbiter.
// The search starts at the pointer, and the pointer moves past the winner once the grant is taken.
module roce_rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_req,
  input  logic         i_accept,
  output logic         o_grant_valid,
  output logic [W-1:0] o_grant_idx
);

  logic [W-1:0] r_ptr;
  logic [W-1:0] w_cand;

  // NOTE: every output gets a default before the search loop, so no path leaves a value held (no latch).
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_idx   = '0;
    w_cand        = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = W'((int'(r_ptr) + k) % N);
      if (!o_grant_valid && i_req[w_cand]) begin
        o_grant_valid = 1'b1;
        o_grant_idx   = w_cand;
      end
    end
  end

  // NOTE: non-blocking assignment, so every flop samples pre-edge values whatever the block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_accept && o_grant_valid) begin
      r_ptr <= (o_grant_idx == W'(N - 1)) ? '0 : o_grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/roce_rnr_retry_scheduler.sv
// Per-QP RNR back-off scheduler: holds a NAKed QP, counts down its RNR timer and enforces the retry limit.
// Expired QPs are arbitrated round-robin into a single registered retry slot.
module roce_rnr_retry_scheduler #(
  parameter int          MAX_QUEUE_PAIRS   = RoCE_params::MAX_QUEUE_PAIRS,
  parameter int          QP_IDX_WIDTH      = RoCE_params::MAX_QUEUE_PAIRS_WIDTH,
  parameter int unsigned TIMER_SCALE_SHIFT = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [MAX_QUEUE_PAIRS-1:0] cfg_qp_open,
  input  logic [2:0]                 cfg_rnr_retry,
  input  logic                       s_rnr_nak_valid,
  input  logic [QP_IDX_WIDTH-1:0]    s_rnr_nak_qp_idx,
  input  logic [4:0]                 s_rnr_nak_timer,
  input  logic [23:0]                s_rnr_nak_psn,
  input  logic                       s_ack_valid,
  input  logic [QP_IDX_WIDTH-1:0]    s_ack_qp_idx,
  output logic                       m_retry_valid,
  input  logic                       m_retry_ready,
  output logic [QP_IDX_WIDTH-1:0]    m_retry_qp_idx,
  output logic [23:0]                m_retry_psn,
  output logic                       m_rnr_error_valid,
  output logic [QP_IDX_WIDTH-1:0]    m_rnr_error_qp_idx,
  output logic [MAX_QUEUE_PAIRS-1:0] qp_hold
);

  import RoCE_params::*;

  rnr_state_t  r_state [MAX_QUEUE_PAIRS];
  logic [31:0] r_timer [MAX_QUEUE_PAIRS];
  logic [2:0]  r_retry [MAX_QUEUE_PAIRS];
  logic [23:0] r_psn   [MAX_QUEUE_PAIRS];

  logic                    r_slot_valid;
  logic [QP_IDX_WIDTH-1:0] r_slot_qp;
  logic [23:0]             r_slot_psn;
  logic                    r_err_valid;
  logic [QP_IDX_WIDTH-1:0] r_err_qp;

  logic                       w_ack_same;
  logic                       w_nak_open;
  logic [2:0]                 w_nak_count;
  logic                       w_limit_hit;
  logic                       w_nak_error;
  logic [31:0]                w_load_value;
  logic [MAX_QUEUE_PAIRS-1:0] w_req;
  logic                       w_grant_valid;
  logic [QP_IDX_WIDTH-1:0]    w_grant_idx;
  logic                       w_slot_free;
  logic                       w_slot_load;
  logic                       w_handshake;

  // An ACK in the same cycle as the NAK means the NAK sees a fresh retry budget.
  always_comb begin
    w_ack_same  = s_ack_valid && (s_ack_qp_idx == s_rnr_nak_qp_idx);
    w_nak_open  = cfg_qp_open[s_rnr_nak_qp_idx];
    w_nak_count = w_ack_same ? 3'd0 : r_retry[s_rnr_nak_qp_idx];
    w_limit_hit = (cfg_rnr_retry != RNR_RETRY_INFINITE) && (w_nak_count == cfg_rnr_retry);
    w_nak_error = s_rnr_nak_valid && w_nak_open && w_limit_hit;
  end

  assign w_load_value = rnr_timer_load(s_rnr_nak_timer, TIMER_SCALE_SHIFT);

  // A QP NAKed this cycle drops out of arbitration so the NAK wins over the grant.
  always_comb begin
    w_req   = '0;
    qp_hold = '0;
    for (int i = 0; i < MAX_QUEUE_PAIRS; i++) begin
      w_req[i]   = cfg_qp_open[i] && (r_state[i] == RNR_PENDING) &&
                   !(s_rnr_nak_valid && (s_rnr_nak_qp_idx == QP_IDX_WIDTH'(i)));
      qp_hold[i] = (r_state[i] != RNR_IDLE);
    end
  end

  assign w_handshake = r_slot_valid && m_retry_ready;
  assign w_slot_free = !r_slot_valid || m_retry_ready;
  assign w_slot_load = w_slot_free && w_grant_valid;

  roce_rr_arbiter #(
    .N (MAX_QUEUE_PAIRS),
    .W (QP_IDX_WIDTH)
  ) u_arbiter (
    .clk           (clk),
    .rst           (rst),
    .i_req         (w_req),
    .i_accept      (w_slot_free),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  // NOTE: per-QP context is a handful of flops, not a RAM, so it is fully reset to guarantee IDLE after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_QUEUE_PAIRS; i++) begin
        r_state[i] <= RNR_IDLE;
        r_timer[i] <= '0;
        r_retry[i] <= '0;
        r_psn[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_QUEUE_PAIRS; i++) begin
        if (!cfg_qp_open[i]) begin
          r_state[i] <= RNR_IDLE;
          r_timer[i] <= '0;
          r_retry[i] <= '0;
        end else if (s_rnr_nak_valid && (s_rnr_nak_qp_idx == QP_IDX_WIDTH'(i))) begin
          if (w_limit_hit) begin
            r_state[i] <= RNR_IDLE;
            r_timer[i] <= '0;
            r_retry[i] <= '0;
          end else begin
            r_state[i] <= RNR_WAIT;
            r_timer[i] <= w_load_value;
            r_retry[i] <= w_nak_count + 3'd1;
            r_psn[i]   <= s_rnr_nak_psn;
          end
        end else begin
          if (s_ack_valid && (s_ack_qp_idx == QP_IDX_WIDTH'(i))) begin
            r_retry[i] <= '0;
          end
          case (r_state[i])
            RNR_WAIT: begin
              r_timer[i] <= r_timer[i] - 32'd1;
              if (r_timer[i] == 32'd1) r_state[i] <= RNR_PENDING;
            end
            RNR_PENDING: begin
              if (w_slot_load && (w_grant_idx == QP_IDX_WIDTH'(i))) r_state[i] <= RNR_ISSUED;
            end
            RNR_ISSUED: begin
              if (w_handshake && (r_slot_qp == QP_IDX_WIDTH'(i))) r_state[i] <= RNR_IDLE;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // The slot snapshots the PSN at grant time, so a later NAK cannot disturb a stalled beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot_valid <= 1'b0;
      r_slot_qp    <= '0;
      r_slot_psn   <= '0;
      r_err_valid  <= 1'b0;
      r_err_qp     <= '0;
    end else begin
      if (w_slot_load) begin
        r_slot_valid <= 1'b1;
        r_slot_qp    <= w_grant_idx;
        r_slot_psn   <= r_psn[w_grant_idx];
      end else if (m_retry_ready) begin
        r_slot_valid <= 1'b0;
      end
      r_err_valid <= w_nak_error;
      if (w_nak_error) r_err_qp <= s_rnr_nak_qp_idx;
    end
  end

  assign m_retry_valid      = r_slot_valid;
  assign m_retry_qp_idx     = r_slot_qp;
  assign m_retry_psn        = r_slot_psn;
  assign m_rnr_error_valid  = r_err_valid;
  assign m_rnr_error_qp_idx = r_err_qp;

endmodule

// File: doc/roce_rnr_retry_scheduler.md
# roce_rnr_retry_scheduler

Per-QP Receiver-Not-Ready (RNR) back-off scheduler for the RoCEv2 requester.
- On an RNR NAK for a QP, it holds that QP's TX, counts down the IB-specified RNR timer selected by the NAK's 5-bit timer code, and enforces the RNR retry limit.
- When the timer expires, it requests a resend; expired QPs are arbitrated round-robin onto one valid/ready retry stream consumed by the TX work-request sequencer.
- It sits between the AETH decoder (NAK/ACK input) and the TX sequencer.

## Interface
Parameters:
- MAX_QUEUE_PAIRS, RoCE_params::MAX_QUEUE_PAIRS (4): number of QPs handled.
- QP_IDX_WIDTH, RoCE_params::MAX_QUEUE_PAIRS_WIDTH (2): QP index width.
- TIMER_SCALE_SHIFT, 0: each loaded timer value is RNR_TIMER_VALUES[code] >> shift, floored at 1. Non-zero only in simulation.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cfg_qp_open  in  MAX_QUEUE_PAIRS  per-QP RTS enable; low forces that QP to IDLE.
- cfg_rnr_retry  in  3  RNR retry limit; 7 = infinite.
- s_rnr_nak_valid  in  1  single-cycle RNR NAK event.
- s_rnr_nak_qp_idx  in  QP_IDX_WIDTH  QP of the NAK.
- s_rnr_nak_timer  in  5  AETH syndrome timer code.
- s_rnr_nak_psn  in  24  PSN at which to resume.
- s_ack_valid  in  1  single-cycle positive ACK event.
- s_ack_qp_idx  in  QP_IDX_WIDTH  QP of the ACK.
- m_retry_valid  out  1  retry request valid.
- m_retry_ready  in  1  retry request accepted.
- m_retry_qp_idx  out  QP_IDX_WIDTH  QP to resend.
- m_retry_psn  out  24  resume PSN.
- m_rnr_error_valid  out  1  one-cycle pulse: retry limit exceeded.
- m_rnr_error_qp_idx  out  QP_IDX_WIDTH  QP that exceeded the limit.
- qp_hold  out  MAX_QUEUE_PAIRS  per-QP TX hold; high in WAIT, PENDING and ISSUED.

## Operation
Per-QP state: 2-bit state, 32-bit down-counter, 3-bit retry count, 24-bit PSN.

States:
- IDLE: default. On a NAK for this QP:
  - If cfg_rnr_retry != 7 and count == cfg_rnr_retry: pulse error, clear count, stay IDLE.
  - Otherwise: count++, load counter, latch PSN, go to WAIT.
- WAIT: counter decrements every cycle. Counter reaching 1 → PENDING on the next edge.
  - A NAK here applies the same limit check. It either reloads counter and PSN and restarts WAIT, or errors and goes to IDLE.
- PENDING: eligible for arbitration. A NAK applies the same rule as in WAIT.
- ISSUED: the QP occupies the output slot. Goes to IDLE on the handshake (m_retry_valid & m_retry_ready). A NAK while ISSUED takes the QP to WAIT per the rule; the slot is unaffected.

ACK events:
- An ACK clears the retry count in any state.
- An ACK does not change the state or the timer.

Arbitration and output slot:
- The output slot is a register. It loads when it is empty, or in the same cycle its contents are accepted.
- Source is the lowest-index PENDING QP at or after the round-robin pointer. The pointer then moves to the granted index + 1, modulo MAX_QUEUE_PAIRS.
- Once m_retry_valid is high, valid, qp_idx and psn stay stable until ready (AXI-stream rule).

cfg_qp_open[i] low:
- Every cycle: state IDLE, count 0, counter 0, no error pulse.
- A slot already holding QP i still completes its handshake.

Simultaneous events:
- NAK and ACK to the same QP in the same cycle: the NAK is processed with count taken as 0.
- A NAK to the QP being granted in that same cycle: the grant is suppressed and the NAK wins.

## Timing
- Reset values:
  - m_retry_valid 0, m_retry_qp_idx 0, m_retry_psn 0.
  - m_rnr_error_valid 0, m_rnr_error_qp_idx 0.
  - qp_hold 0.
  - All QPs IDLE with count 0 and counter 0; RR pointer 0.
- A NAK sampled at edge 0 loads value V:
  - qp_hold is high after edge 0.
  - PENDING after edge V.
  - m_retry_valid high after edge V+1, provided the slot is free.
- Error pulse: registered, one cycle after the offending NAK edge.
- Throughput: one retry accepted per cycle when ready is held high.
- Reset mid-countdown discards all state immediately; no retry is issued.

## Structure
Additions to RoCE_params:
- typedef enum logic [1:0] {RNR_IDLE, RNR_WAIT, RNR_PENDING, RNR_ISSUED} rnr_state_t
- constant RNR_RETRY_INFINITE = 3'd7

The table RNR_TIMER_VALUES is used as-is.

One sub-module, roce_rr_arbiter: a parameterised round-robin request/grant arbiter with a pointer update on grant. It is reused later by the TX QP scheduler.

## Test plan
- Single NAK: QP 2, code 1, shift 0. qp_hold[2]=1 after 1 cycle; m_retry_valid with qp_idx 2 and the given PSN exactly RNR_TIMER_VALUES[1]+2 cycles after the NAK; qp_hold[2]=0 after the handshake.
- Retry limit: cfg_rnr_retry=2, three NAKs on QP 0 (each after its retry completes). Third → m_rnr_error_valid pulse with qp_idx 0 and no retry; with cfg=7, 10 NAKs give 10 retries.
- Fairness: QPs 0–3 all PENDING in the same cycle, ready held low 5 cycles then high. Grant order is 0,1,2,3; the output stays stable while stalled.
- Reload: NAK code 4 on QP 1, then NAK code 1 with a new PSN 10 cycles later. A single retry carries the new PSN at the code-1 expiry.
- ACK and close: an ACK clears the count so the limit restarts. Dropping cfg_qp_open[3] mid-WAIT → qp_hold[3]=0 next cycle and no retry is issued.
- Async reset asserted mid-countdown and mid-stall → all outputs 0 immediately; no stale retry after release.
